sd_spi_master: RTL and testbench
================================

SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 The block SHALL have parameter FASTDIV, default 2, meaning SCK half-period in clk_sys cycles in fast mode; legal range 2..127.
REQ-002 The block SHALL have parameter SLOWDIV, default 64, meaning SCK half-period in clk_sys cycles in slow (card-init) mode; legal range 2..127.
REQ-003 The block SHALL have port clk_sys  input  1  system clock; all logic rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port din  input  8  CPU write data.
REQ-006 The block SHALL have port data_wr  input  1  one-cycle pulse: start transfer sending din.
REQ-007 The block SHALL have port data_rd  input  1  one-cycle pulse: start transfer sending 8'hFF.
REQ-008 The block SHALL have port cs_wr  input  1  one-cycle pulse: load control register from din[1:0].
REQ-009 The block SHALL have port dout  output  8  last completed received byte.
REQ-010 The block SHALL have port busy  output  1  transfer in progress.
REQ-011 The block SHALL have port spi_cs  output  1  card select, active low (drives sd_cs).
REQ-012 The block SHALL have port spi_sck  output  1  serial clock (drives sd_sck).
REQ-013 The block SHALL have port spi_mosi  output  1  serial data out (drives sd_sdi).
REQ-014 The block SHALL have port spi_miso  input  1  serial data in (from sd_sdo), synchronous to clk_sys.

Function
REQ-015 The block SHALL implement SPI mode 0: SCK idles low, MOSI changes only while SCK low, MISO sampled on the clk_sys edge that raises SCK, MSB first.
REQ-016 The block SHALL implement states IDLE, LOW, HIGH, with a 7-bit divider counter and 3-bit bit counter.
REQ-017 In IDLE, on data_wr (or data_rd) the block SHALL load tx shift register with din (or 8'hFF), drive spi_mosi with bit 7, set busy, set divider to DIV-1, clear bit counter, enter LOW; DIV = SLOWDIV if slow bit set, else FASTDIV, latched at start.
REQ-018 In LOW, when divider reaches 0, the block SHALL set spi_sck=1, shift spi_miso into rx LSB, reload divider, enter HIGH.
REQ-019 In HIGH, when divider reaches 0, the block SHALL set spi_sck=0; if bit counter is 7 it SHALL copy rx (including the bit just sampled) into dout, clear busy, enter IDLE; else shift tx, drive next bit on spi_mosi, increment bit counter, reload divider, enter LOW.
REQ-020 A transfer SHALL last exactly 16*DIV clk_sys cycles from the start-pulse edge to busy deassertion; busy SHALL be high on the cycle after the start pulse.
REQ-021 dout SHALL change only at transfer completion; a data_rd pulse returns the previous dout and launches the next byte.
REQ-022 data_wr and data_rd SHALL be ignored while busy; no queueing, no state change.
REQ-023 data_wr and data_rd in the same cycle SHALL start one transfer sending din (data_wr priority).
REQ-024 On cs_wr in IDLE the block SHALL set spi_cs=din[0] and slow bit=din[1] next cycle; cs_wr while busy SHALL be ignored.
REQ-025 cs_wr with data_wr/data_rd in the same IDLE cycle SHALL apply both: new spi_cs and slow bit take effect and the transfer uses the new DIV.
REQ-026 spi_sck SHALL be low whenever state is IDLE; spi_mosi SHALL be 1 in IDLE.

Reset
REQ-027 While rst_n=0 the block SHALL immediately force: state IDLE, spi_cs=1, spi_sck=0, spi_mosi=1, slow bit=1, busy=0, dout=8'hFF, counters 0.
REQ-028 Reset asserted mid-transfer SHALL abort it with no dout update; first transfer after release SHALL behave as from power-up.

Verification
REQ-029 Fast write: cs_wr din=8'h00, then data_wr din=8'h40, MISO model returns 8'hA5 -> MOSI 0,1,0,0,0,0,0,0 at SCK rises, 8 SCK pulses of 2 cycles high/2 low, busy high 32 cycles, dout=8'hA5.
REQ-030 Slow mode: after reset (slow=1) data_rd -> MOSI all 1, busy high 1024 cycles, dout = sampled MISO byte.
REQ-031 Collision: data_wr 8'h12 then data_wr 8'h34 and cs_wr din=8'h01 at cycle +5 -> only 8'h12 shifted, spi_cs stays 0, busy length unchanged.
REQ-032 Reset mid-transfer: rst_n low at cycle 10 of a fast transfer -> spi_cs=1, spi_sck=0, busy=0, dout=8'hFF same cycle.
REQ-033 End-to-end with sd_card: cs low, send 8'h40,8'h00,8'h00,8'h00,8'h00,8'h95, then data_rd pulses -> an R1 byte 8'h01 appears in dout within the first two reads.

Source files
------------

// File: rtl/sd_spi_master.sv
// rtl/sd_spi_master.sv - SD card SPI mode-0 byte-transfer master
//
// Purpose:
//   Shifts one byte out on spi_mosi while shifting one byte in from
//   spi_miso, SPI mode 0, MSB first. SCK half-period is FASTDIV or SLOWDIV
//   clk_sys cycles, chosen by the slow bit of the control register at the
//   moment a transfer starts.
//
// Parameters:
//   FASTDIV   SCK half-period in clk_sys cycles, fast mode (2..127)
//   SLOWDIV   SCK half-period in clk_sys cycles, card-init mode (2..127)
//
// Ports:
//   clk_sys   in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   [7:0] CPU write data / control bits
//   data_wr   in   pulse: start transfer sending din
//   data_rd   in   pulse: start transfer sending 8'hFF
//   cs_wr     in   pulse: spi_cs <= din[0], slow <= din[1] (idle only)
//   dout      out  [7:0] last completed received byte
//   busy      out  transfer in progress
//   spi_cs    out  card select, active low
//   spi_sck   out  serial clock
//   spi_mosi  out  serial data to card
//   spi_miso  in   serial data from card, synchronous to clk_sys

module sd_spi_master #(
  parameter int FASTDIV = 2,
  parameter int SLOWDIV = 64
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       data_wr,
  input  logic       data_rd,
  input  logic       cs_wr,
  output logic [7:0] dout,
  output logic       busy,
  output logic       spi_cs,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  localparam logic [6:0] FAST_RELOAD = 7'(FASTDIV - 1);
  localparam logic [6:0] SLOW_RELOAD = 7'(SLOWDIV - 1);

  state_t     r_state,      w_state;
  logic [6:0] r_div_cnt,    w_div_cnt;
  logic [6:0] r_div_reload, w_div_reload;
  logic [2:0] r_bit_cnt,    w_bit_cnt;
  logic [7:0] r_tx,         w_tx;
  logic [7:0] r_rx,         w_rx;
  logic [7:0] r_dout,       w_dout;
  logic       r_cs,         w_cs;
  logic       r_slow,       w_slow;
  logic       r_sck,        w_sck;

  logic       w_start;
  logic       w_slow_eff;
  logic [6:0] w_start_reload;

  // r_tx[7] is the bit currently on MOSI; the register is refilled with
  // ones as it shifts so MOSI idles high without a separate flop.
  assign dout     = r_dout;
  assign busy     = (r_state != S_IDLE);
  assign spi_cs   = r_cs;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_tx[7];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_div_cnt    <= 7'd0;
      r_div_reload <= 7'd0;
      r_bit_cnt    <= 3'd0;
      r_tx         <= 8'hFF;
      r_rx         <= 8'h00;
      r_dout       <= 8'hFF;
      r_cs         <= 1'b1;
      r_slow       <= 1'b1;
      r_sck        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_div_cnt    <= w_div_cnt;
      r_div_reload <= w_div_reload;
      r_bit_cnt    <= w_bit_cnt;
      r_tx         <= w_tx;
      r_rx         <= w_rx;
      r_dout       <= w_dout;
      r_cs         <= w_cs;
      r_slow       <= w_slow;
      r_sck        <= w_sck;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_div_cnt    = r_div_cnt;
    w_div_reload = r_div_reload;
    w_bit_cnt    = r_bit_cnt;
    w_tx         = r_tx;
    w_rx         = r_rx;
    w_dout       = r_dout;
    w_cs         = r_cs;
    w_slow       = r_slow;
    w_sck        = r_sck;

    w_start        = data_wr | data_rd;
    // A cs_wr in the same idle cycle as a start selects the divider too.
    w_slow_eff     = cs_wr ? din[1] : r_slow;
    w_start_reload = w_slow_eff ? SLOW_RELOAD : FAST_RELOAD;

    case (r_state)
      S_IDLE: begin
        w_sck = 1'b0;
        if (cs_wr) begin
          w_cs   = din[0];
          w_slow = din[1];
        end
        if (w_start) begin
          // data_wr wins when both start pulses arrive together.
          w_tx         = data_wr ? din : 8'hFF;
          w_div_reload = w_start_reload;
          w_div_cnt    = w_start_reload;
          w_bit_cnt    = 3'd0;
          w_state      = S_LOW;
        end
      end

      S_LOW: begin
        if (r_div_cnt == 7'd0) begin
          w_sck     = 1'b1;
          w_rx      = {r_rx[6:0], spi_miso};
          w_div_cnt = r_div_reload;
          w_state   = S_HIGH;
        end else begin
          w_div_cnt = r_div_cnt - 7'd1;
        end
      end

      S_HIGH: begin
        if (r_div_cnt == 7'd0) begin
          w_sck = 1'b0;
          if (r_bit_cnt == 3'd7) begin
            // r_rx already holds the bit sampled on the last rising edge.
            w_dout    = r_rx;
            w_tx      = 8'hFF;
            w_div_cnt = 7'd0;
            w_state   = S_IDLE;
          end else begin
            w_tx      = {r_tx[6:0], 1'b1};
            w_bit_cnt = r_bit_cnt + 3'd1;
            w_div_cnt = r_div_reload;
            w_state   = S_LOW;
          end
        end else begin
          w_div_cnt = r_div_cnt - 7'd1;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_sck   = 1'b0;
        w_tx    = 8'hFF;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// tb/tb_sd_spi_master.sv - self-checking bench for sd_spi_master

module tb_sd_spi_master;

  localparam int FASTDIV = 2;
  localparam int SLOWDIV = 64;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] din     = 8'h00;
  logic       data_wr = 1'b0;
  logic       data_rd = 1'b0;
  logic       cs_wr   = 1'b0;
  logic [7:0] dout;
  logic       busy;
  logic       spi_cs;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  always #5 clk_sys = ~clk_sys;

  sd_spi_master #(
    .FASTDIV(FASTDIV),
    .SLOWDIV(SLOWDIV)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .din     (din),
    .data_wr (data_wr),
    .data_rd (data_rd),
    .cs_wr   (cs_wr),
    .dout    (dout),
    .busy    (busy),
    .spi_cs  (spi_cs),
    .spi_sck (spi_sck),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  typedef struct {
    logic       use_cs;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] miso;
    logic [7:0] e_dout;
    logic [7:0] e_mosi;
    int         e_cycles;
    logic       e_cs;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic [7:0] mosi;
    int         cycles;
    logic       cs;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] card_q[$];
  logic [7:0] cmd_buf[$];
  vec_t       vecs[8];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] slave_byte = 8'hFF;
  int         slave_idx  = 8;
  int         rise_cnt   = 0;
  int         busy_cnt   = 0;
  int         viol       = 0;
  int         hi_run     = 0;
  int         cur_div    = FASTDIV;
  logic [7:0] mon_mosi   = 8'h00;
  logic       prev_sck   = 1'b0;
  logic       prev_mosi  = 1'b1;
  logic       card_mode  = 1'b0;
  logic [7:0] last_dout  = 8'hFF;

  // Slave presents bit 7 first and advances after every SCK rise.
  assign spi_miso = (slave_idx < 8) ? slave_byte[3'(7 - slave_idx)] : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Minimal SD card: a CMD0 frame queues NCR filler then R1 = 8'h01.
  task automatic card_byte(input logic [7:0] b);
    if (cmd_buf.size() == 0 && b == 8'hFF) return;
    cmd_buf.push_back(b);
    if (cmd_buf.size() == 6) begin
      if (cmd_buf[0] == 8'h40 && cmd_buf[5] == 8'h95) begin
        card_q.push_back(8'hFF);
        card_q.push_back(8'h01);
      end
      cmd_buf.delete();
    end
  endtask

  function automatic logic [7:0] next_card();
    if (card_q.size() > 0) return card_q.pop_front();
    return 8'hFF;
  endfunction

  // One cycle: wait for the falling clock edge, then observe the bus.
  task automatic tick();
    @(negedge clk_sys);
    if (busy) busy_cnt++;
    if (!busy && (spi_sck || !spi_mosi)) viol++;
    if (spi_sck && (spi_mosi != prev_mosi)) viol++;
    if (spi_sck) hi_run++;
    if (!spi_sck && prev_sck) begin
      if (hi_run != cur_div) viol++;
      hi_run = 0;
    end
    if (spi_sck && !prev_sck) begin
      rise_cnt++;
      mon_mosi = {mon_mosi[6:0], spi_mosi};
      slave_idx++;
      if (card_mode && rise_cnt == 8) card_byte(mon_mosi);
    end
    prev_sck  = spi_sck;
    prev_mosi = spi_mosi;
  endtask

  task automatic arm(input logic [7:0] s, input int div);
    slave_byte = s;
    slave_idx  = 0;
    rise_cnt   = 0;
    busy_cnt   = 0;
    viol       = 0;
    hi_run     = 0;
    mon_mosi   = 8'h00;
    cur_div    = div;
  endtask

  task automatic pulse(input logic use_cs, input logic wr, input logic rd, input logic [7:0] d);
    din     = d;
    cs_wr   = use_cs;
    data_wr = wr;
    data_rd = rd;
    tick();
    cs_wr   = 1'b0;
    data_wr = 1'b0;
    data_rd = 1'b0;
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (i == 4) chk({name, "_dout_hold"}, dout, last_dout);
      tick();
    end
    chk({name, "_done"}, done, 1);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({name, "_dout"},   dout,     e.dout);
      chk({name, "_mosi"},   mon_mosi, e.mosi);
      chk({name, "_cycles"}, busy_cnt, e.cycles);
      chk({name, "_cs"},     spi_cs,   e.cs);
      chk({name, "_rises"},  rise_cnt, 8);
      chk({name, "_bus"},    viol,     0);
      last_dout = e.dout;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r1_seen;
    logic [7:0] cmd[6];

    vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h40, 8'hA5, 8'hA5, 8'h40, 32,   1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'hC3, 8'h3C, 8'h3C, 8'hC3, 32,   1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h12, 8'h5A, 8'h5A, 8'hFF, 32,   1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h81, 8'h00, 8'h00, 8'h81, 32,   1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h02, 8'h96, 8'h96, 8'hFF, 1024, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h7C, 8'hFF, 8'hFF, 8'h7C, 32,   1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h80, 8'h80, 8'h01, 32,   1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h6E, 8'h6E, 8'hFF, 32,   1'b0};

    // Reset values while reset is held.
    repeat (3) tick();
    chk("rst_busy", busy,     0);
    chk("rst_cs",   spi_cs,   1);
    chk("rst_sck",  spi_sck,  0);
    chk("rst_mosi", spi_mosi, 1);
    chk("rst_dout", dout,     8'hFF);
    rst_n = 1'b1;
    tick();

    // Power-up is slow mode: a read shifts all ones for 16*SLOWDIV cycles.
    arm(8'h3C, SLOWDIV);
    sb.push_back('{8'h3C, 8'hFF, 16 * SLOWDIV, 1'b1});
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    chk("slow_busy_next", busy, 1);
    wait_done("slow_rd");

    // Select card, fast mode.
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    chk("cs_low", spi_cs, 0);
    chk("cs_no_xfer", busy, 0);

    for (int i = 0; i < 8; i++) begin
      arm(vecs[i].miso, vecs[i].e_cycles / 16);
      sb.push_back('{vecs[i].e_dout, vecs[i].e_mosi, vecs[i].e_cycles, vecs[i].e_cs});
      pulse(vecs[i].use_cs, vecs[i].wr, vecs[i].rd, vecs[i].din);
      wait_done($sformatf("vec%0d", i));
    end

    // Start and control pulses arriving while busy are dropped.
    arm(8'h55, FASTDIV);
    sb.push_back('{8'h55, 8'h12, 16 * FASTDIV, 1'b0});
    pulse(1'b0, 1'b1, 1'b0, 8'h12);
    repeat (3) tick();
    pulse(1'b0, 1'b1, 1'b0, 8'h34);
    pulse(1'b1, 1'b0, 1'b0, 8'h01);
    chk("collide_cs_mid", spi_cs, 0);
    wait_done("collide");
    repeat (4) tick();
    chk("collide_no_restart", busy, 0);

    // Reset mid-transfer forces idle outputs without waiting for a clock.
    arm(8'hAA, FASTDIV);
    pulse(1'b0, 1'b1, 1'b0, 8'hF0);
    repeat (9) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cs",   spi_cs,   1);
    chk("midrst_sck",  spi_sck,  0);
    chk("midrst_busy", busy,     0);
    chk("midrst_dout", dout,     8'hFF);
    chk("midrst_mosi", spi_mosi, 1);
    tick();
    rst_n = 1'b1;
    last_dout = 8'hFF;
    tick();

    // After reset the block is back in slow mode with card deselected.
    arm(8'h99, SLOWDIV);
    sb.push_back('{8'h99, 8'h5A, 16 * SLOWDIV, 1'b1});
    pulse(1'b0, 1'b1, 1'b0, 8'h5A);
    wait_done("post_rst");

    // CMD0 against the card model; R1 must arrive within two reads.
    card_mode = 1'b1;
    cmd_buf.delete();
    card_q.delete();
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    chk("card_cs_low", spi_cs, 0);
    cmd[0] = 8'h40; cmd[1] = 8'h00; cmd[2] = 8'h00;
    cmd[3] = 8'h00; cmd[4] = 8'h00; cmd[5] = 8'h95;
    for (int k = 0; k < 6; k++) begin
      arm(next_card(), FASTDIV);
      sb.push_back('{8'hFF, cmd[k], 16 * FASTDIV, 1'b0});
      pulse(1'b0, 1'b1, 1'b0, cmd[k]);
      wait_done($sformatf("cmd%0d", k));
    end
    r1_seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      arm(next_card(), FASTDIV);
      sb.push_back('{(k == 0) ? 8'hFF : 8'h01, 8'hFF, 16 * FASTDIV, 1'b0});
      pulse(1'b0, 1'b0, 1'b1, 8'h00);
      wait_done($sformatf("rd%0d", k));
      if (dout == 8'h01) r1_seen = 1'b1;
    end
    chk("card_r1", r1_seen, 1);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
